// File: rtl/video_timing_pg.sv
// -----------------------------------------------------------------------------
// video_timing_pg
//
// Video timing and test-pattern generator. It produces HSYNC, VSYNC and DE
// together with NUM_PORTS pixels per clock. Each pixel is an RGB triple of
// DATA_W-bit components. It is used as a synthesizable pixel source at the
// head of the bring-up pipeline.
//
// Line and frame layout, in region order: sync, back porch, active,
// front porch. Every output is registered once from the counter state, so
// vs/hs/de/pix/frame_start are mutually cycle-aligned.
//
// Ports:
//   clk          in   sole clock
//   rst          in   synchronous reset, active-high
//   en           in   run request, sampled in IDLE and at the frame end
//   mode         in   pattern: 0 solid, 1 h-ramp, 2 v-ramp, 3 checker
//   solid_rgb    in   solid colour {R,G,B}
//   vs           out  vertical sync (active level VS_POL)
//   hs           out  horizontal sync (active level HS_POL)
//   de           out  data enable
//   pix          out  NUM_PORTS pixels; port p at [(p+1)*3*DATA_W-1 : p*3*DATA_W]
//   frame_start  out  one-clock pulse on the first clock of each frame
//   frame_cnt    out  count of frames started, wraps at 16 bits
// -----------------------------------------------------------------------------
module video_timing_pg #(
   parameter int   NUM_PORTS = 8,
   parameter int   DATA_W    = 8,
   parameter int   H_ACTIVE  = 240,
   parameter int   H_FP      = 88,
   parameter int   H_SYNC    = 44,
   parameter int   H_BP      = 148,
   parameter int   V_ACTIVE  = 30,
   parameter int   V_FP      = 4,
   parameter int   V_SYNC    = 5,
   parameter int   V_BP      = 36,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   CHK_SHIFT = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [1:0]                    mode,
   input  logic [3*DATA_W-1:0]           solid_rgb,
   output logic                          vs,
   output logic                          hs,
   output logic                          de,
   output logic [NUM_PORTS*3*DATA_W-1:0] pix,
   output logic                          frame_start,
   output logic [15:0]                   frame_cnt
);

   localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_W         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_W         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int H_ACT_END   = H_SYNC + H_BP + H_ACTIVE;
   localparam int V_ACT_START = V_SYNC + V_BP;
   localparam int V_ACT_END   = V_SYNC + V_BP + V_ACTIVE;
   localparam int PIX_W       = 3 * DATA_W;
   localparam int BUS_W       = NUM_PORTS * PIX_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Pattern for one pixel at coordinates (x, y). x and y are only
   // meaningful inside the active window; outside it the caller blanks.
   function automatic logic [PIX_W-1:0] pattern(
      input logic [1:0]       m,
      input logic [PIX_W-1:0] solid,
      input logic [31:0]      x,
      input logic [31:0]      y
   );
      logic [DATA_W-1:0] c;
      c = '0;
      case (m)
         2'd0:    return solid;
         2'd1:    c = x[DATA_W-1:0];
         2'd2:    c = y[DATA_W-1:0];
         default: c = {DATA_W{x[CHK_SHIFT] ^ y[CHK_SHIFT]}};
      endcase
      return {c, c, c};
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [H_W-1:0]     r_h_cnt_p0;
   logic [V_W-1:0]     r_v_cnt_p0;
   logic [H_W-1:0]     w_h_cnt_nxt;
   logic [V_W-1:0]     w_v_cnt_nxt;
   logic               w_h_last;
   logic               w_v_last;
   logic               w_latch;

   logic [1:0]         r_mode;
   logic [PIX_W-1:0]   r_solid;

   logic               w_run_p0;
   logic [31:0]        w_h32_p0;
   logic [31:0]        w_v32_p0;
   logic [31:0]        w_ax_p0;
   logic [31:0]        w_ay_p0;
   logic               w_hs_act_p0;
   logic               w_vs_act_p0;
   logic               w_de_p0;
   logic               w_fs_p0;
   logic [BUS_W-1:0]   w_pix_p0;

   logic               r_hs_p1;
   logic               r_vs_p1;
   logic               r_de_p1;
   logic               r_fs_p1;
   logic [BUS_W-1:0]   r_pix_p1;
   logic [15:0]        r_frame_cnt_p1;

   assign w_h_last = (r_h_cnt_p0 == H_W'(H_TOTAL - 1));
   assign w_v_last = (r_v_cnt_p0 == V_W'(V_TOTAL - 1));

   // Next-state and counter logic. The pattern selection is re-latched on
   // entry to RUN and at each frame wrap, so a frame never mixes patterns.
   always_comb begin
      w_state_nxt = r_state;
      w_h_cnt_nxt = r_h_cnt_p0;
      w_v_cnt_nxt = r_v_cnt_p0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_h_cnt_nxt = '0;
            w_v_cnt_nxt = '0;
            if (en) begin
               w_state_nxt = S_RUN;
               w_latch     = 1'b1;
            end
         end
         S_RUN: begin
            if (w_h_last) begin
               w_h_cnt_nxt = '0;
               if (w_v_last) begin
                  // en is only honoured here, so a frame is never truncated.
                  w_v_cnt_nxt = '0;
                  if (en) begin
                     w_latch = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_v_cnt_nxt = r_v_cnt_p0 + V_W'(1);
               end
            end else begin
               w_h_cnt_nxt = r_h_cnt_p0 + H_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_h_cnt_nxt = '0;
            w_v_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_h_cnt_p0 <= '0;
         r_v_cnt_p0 <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_h_cnt_p0 <= w_h_cnt_nxt;
         r_v_cnt_p0 <= w_v_cnt_nxt;
      end
   end

   // Latched pattern selection; holds its value while IDLE.
   always_ff @(posedge clk) begin
      if (w_latch) begin
         r_mode  <= mode;
         r_solid <= solid_rgb;
      end
   end

   // ---- stage p0: decode counter state into sync, DE and pixel values ----
   assign w_run_p0    = (r_state == S_RUN);
   assign w_h32_p0    = 32'(r_h_cnt_p0);
   assign w_v32_p0    = 32'(r_v_cnt_p0);
   assign w_ax_p0     = w_h32_p0 - 32'(H_ACT_START);
   assign w_ay_p0     = w_v32_p0 - 32'(V_ACT_START);
   assign w_hs_act_p0 = w_run_p0 && (w_h32_p0 < 32'(H_SYNC));
   assign w_vs_act_p0 = w_run_p0 && (w_v32_p0 < 32'(V_SYNC));
   assign w_de_p0     = w_run_p0
                        && (w_h32_p0 >= 32'(H_ACT_START)) && (w_h32_p0 < 32'(H_ACT_END))
                        && (w_v32_p0 >= 32'(V_ACT_START)) && (w_v32_p0 < 32'(V_ACT_END));
   assign w_fs_p0     = w_run_p0 && (r_h_cnt_p0 == '0) && (r_v_cnt_p0 == '0);

   always_comb begin
      w_pix_p0 = '0;
      if (w_de_p0) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            w_pix_p0[p*PIX_W +: PIX_W] =
               pattern(r_mode, r_solid, (w_ax_p0 * 32'(NUM_PORTS)) + 32'(p), w_ay_p0);
         end
      end
   end

   // ---- stage p1: output registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_p1        <= ~HS_POL;
         r_vs_p1        <= ~VS_POL;
         r_de_p1        <= 1'b0;
         r_fs_p1        <= 1'b0;
         r_pix_p1       <= '0;
         r_frame_cnt_p1 <= '0;
      end else begin
         r_hs_p1  <= w_hs_act_p0 ? HS_POL : ~HS_POL;
         r_vs_p1  <= w_vs_act_p0 ? VS_POL : ~VS_POL;
         r_de_p1  <= w_de_p0;
         r_fs_p1  <= w_fs_p0;
         r_pix_p1 <= w_pix_p0;
         if (w_fs_p0) begin
            r_frame_cnt_p1 <= r_frame_cnt_p1 + 16'd1;
         end
      end
   end

   assign hs          = r_hs_p1;
   assign vs          = r_vs_p1;
   assign de          = r_de_p1;
   assign frame_start = r_fs_p1;
   assign pix         = r_pix_p1;
   assign frame_cnt   = r_frame_cnt_p1;

endmodule

// File: tb/tb_video_timing_pg.sv
module tb_video_timing_pg;

   localparam int NP   = 2;
   localparam int DW   = 8;
   localparam int HSW  = 2;
   localparam int HBP  = 2;
   localparam int HACT = 4;
   localparam int HFP  = 2;
   localparam int VSW  = 1;
   localparam int VBP  = 1;
   localparam int VACT = 3;
   localparam int VFP  = 1;
   localparam int CHK  = 3;
   localparam logic HSP = 1'b0;
   localparam logic VSP = 1'b0;
   localparam int HT   = HSW + HBP + HACT + HFP;   // 10
   localparam int VT   = VSW + VBP + VACT + VFP;   // 6
   localparam int FT   = HT * VT;                  // 60
   localparam int PW   = 3 * DW;
   localparam int BW   = NP * PW;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [1:0]     mode;
   logic [PW-1:0]  solid;
   logic           vs, hs, de, frame_start;
   logic [BW-1:0]  pix;
   logic [15:0]    frame_cnt;

   always #5 clk = ~clk;

   video_timing_pg #(
      .NUM_PORTS(NP), .DATA_W(DW),
      .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(HSP), .VS_POL(VSP), .CHK_SHIFT(CHK)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
      .vs(vs), .hs(hs), .de(de), .pix(pix),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   typedef struct packed {
      logic          vs;
      logic          hs;
      logic          de;
      logic          fs;
      logic [15:0]   fc;
      logic [BW-1:0] pix;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: a running flag and a position within the frame
   // (0..FT-1); everything else follows from arithmetic on that position.
   bit            m_run = 1'b0;
   int            m_t   = 0;
   logic [15:0]   m_fc  = 16'd0;
   logic [1:0]    m_mode = 2'd0;
   logic [PW-1:0] m_solid = '0;
   int            force_req  = 0;
   int            force_seen = 0;

   function automatic bit in_active(input int t);
      int h = t % HT;
      int v = t / HT;
      return (h >= HSW + HBP) && (h < HSW + HBP + HACT) &&
             (v >= VSW + VBP) && (v < VSW + VBP + VACT);
   endfunction

   function automatic logic [BW-1:0] exp_pix(input int t, input logic [1:0] md,
                                             input logic [PW-1:0] sol);
      logic [BW-1:0] r = '0;
      logic [DW-1:0] c;
      int x;
      int y = t / HT - (VSW + VBP);
      if (!in_active(t)) return '0;
      for (int p = 0; p < NP; p++) begin
         x = (t % HT - (HSW + HBP)) * NP + p;
         case (md)
            2'd0: r[p*PW +: PW] = sol;
            2'd1: begin c = DW'(x % (1 << DW)); r[p*PW +: PW] = {c, c, c}; end
            2'd2: begin c = DW'(y % (1 << DW)); r[p*PW +: PW] = {c, c, c}; end
            default: begin
               c = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? '1 : '0;
               r[p*PW +: PW] = {c, c, c};
            end
         endcase
      end
      return r;
   endfunction

   // Model: predicts the outputs that follow each clock edge.
   always @(posedge clk) begin
      exp_t e;
      e.vs  = ~VSP;
      e.hs  = ~HSP;
      e.de  = 1'b0;
      e.fs  = 1'b0;
      e.pix = '0;
      if (force_req != force_seen) begin
         m_fc       = 16'hFFFF;
         force_seen = force_req;
      end
      if (rst) begin
         m_run = 1'b0;
         m_t   = 0;
         m_fc  = 16'd0;
      end else if (m_run) begin
         e.hs  = ((m_t % HT) < HSW) ? HSP : ~HSP;
         e.vs  = ((m_t / HT) < VSW) ? VSP : ~VSP;
         e.de  = in_active(m_t);
         e.pix = exp_pix(m_t, m_mode, m_solid);
         e.fs  = (m_t == 0);
         if (m_t == 0) m_fc = m_fc + 16'd1;
         m_t = m_t + 1;
         if (m_t == FT) begin
            m_t = 0;
            if (en) begin
               m_mode  = mode;
               m_solid = solid;
            end else begin
               m_run = 1'b0;
            end
         end
      end else if (en) begin
         m_run   = 1'b1;
         m_t     = 0;
         m_mode  = mode;
         m_solid = solid;
      end
      e.fc = m_fc;
      sb_q.push_back(e);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every clock the DUT presents a full output set.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
         e = sb_q.pop_front();
         chk("vs", 64'(vs), 64'(e.vs));
         chk("hs", 64'(hs), 64'(e.hs));
         chk("de", 64'(de), 64'(e.de));
         chk("frame_start", 64'(frame_start), 64'(e.fs));
         chk("frame_cnt", 64'(frame_cnt), 64'(e.fc));
         chk("pix", 64'(pix), 64'(e.pix));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits (at negedges) until the counter position equals target.
   task automatic wait_pos(input int target, input string nm);
      int n = 0;
      while (!(m_run && m_t == target) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL wait_%s: position %0d not reached", nm, target);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      en    = 1'b1;
      mode  = 2'd1;
      solid = 24'h123456;

      // Reset for three clocks, then start-up.
      cycles(3);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("startup_vs", 64'(vs), 64'(VSP));
      chk("startup_fs", 64'(frame_start), 64'd1);
      @(negedge clk);

      // Two frames of h-ramp.
      cycles(2 * FT);

      // Solid for the next frame, then v-ramp requested at v_cnt=3.
      mode  = 2'd0;
      solid = 24'h123456;
      wait_pos(0, "solid_frame");
      wait_pos(3 * HT, "mode_switch");
      mode = 2'd2;
      wait_pos(0, "vramp_frame");
      cycles(FT + 5);

      // en dropped mid-frame; the frame must complete, then idle.
      wait_pos(2 * HT, "en_drop");
      en = 1'b0;
      cycles(90);
      en   = 1'b1;
      mode = 2'd3;
      cycles(2 * FT);

      // Reset in the middle of the active window.
      wait_pos(3 * HT + 5, "rst_mid");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cycles(FT);

      // frame_cnt wrap from 0xFFFF.
      wait_pos(25, "force");
      force dut.r_frame_cnt_p1 = 16'hFFFF;
      force_req = force_req + 1;
      #1;
      release dut.r_frame_cnt_p1;
      cycles(2 * FT);

      // Randomized phase.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) mode  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) solid = PW'($urandom);
         if ($urandom_range(0, 59) == 0) en    = ~en;
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      en  = 1'b1;
      cycles(FT + 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_timing_pg.md
# video_timing_pg

Parametrised video timing and test-pattern generator. Emits HSYNC/VSYNC/DE plus `NUM_PORTS` pixels per clock, each an RGB triple of `DATA_W`-bit components. Sits at the head of the simulation and bring-up pipeline as a synthesizable pixel source for the DCT path. It replaces file-driven stimulus with selectable generated patterns and aligns all outputs to one register stage.

## Interface
Parameters:
- `NUM_PORTS`, 8: pixels per clock.
- `DATA_W`, 8: bits per colour component.
- `H_ACTIVE`, 240: active clocks per line; pixels per line = `H_ACTIVE*NUM_PORTS`.
- `H_FP`, 88: horizontal front porch, in clocks.
- `H_SYNC`, 44: horizontal sync width, in clocks.
- `H_BP`, 148: horizontal back porch, in clocks.
- `V_ACTIVE`, 30: active lines per frame.
- `V_FP`, 4: vertical front porch, in lines.
- `V_SYNC`, 5: vertical sync width, in lines.
- `V_BP`, 36: vertical back porch, in lines.
- `HS_POL`, 1'b0: HSYNC active level.
- `VS_POL`, 1'b0: VSYNC active level.
- `CHK_SHIFT`, 3: checker square size is 2^`CHK_SHIFT` pixels.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  run request; sampled only in IDLE and at the frame end.
- `mode`  in  2  pattern select; 0 solid, 1 h-ramp, 2 v-ramp, 3 checker.
- `solid_rgb`  in  3*DATA_W  solid colour {R,G,B}.
- `vs`  out  1  vertical sync.
- `hs`  out  1  horizontal sync.
- `de`  out  1  data enable.
- `pix`  out  NUM_PORTS*3*DATA_W  pixel bus. Port p occupies bits [(p+1)*3*DATA_W-1 : p*3*DATA_W], packed {R,G,B}, R in the MSBs.
- `frame_start`  out  1  one-clock pulse on the first clock of each frame.
- `frame_cnt`  out  16  count of frames started; wraps.

## Operation
- Derived sizes: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- `h_cnt` runs 0..H_TOTAL-1. `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
- Region order within both a line and a frame: sync, back porch, active, front porch.
  - HSYNC is asserted for h_cnt < H_SYNC.
  - VSYNC is asserted for v_cnt < V_SYNC.
  - DE is asserted when h_cnt lies in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt lies in the equivalent V window.
- FSM states:
  - IDLE: counters held at 0; outputs at their inactive values. If `en`=1, go to RUN with h=v=0 on the next edge.
  - RUN: counters advance every clock. At h=H_TOTAL-1 and v=V_TOTAL-1:
    - `en`=1: wrap to 0,0 and stay in RUN.
    - `en`=0: go to IDLE.
  - Dropping `en` mid-frame never truncates a frame.
- `mode` and `solid_rgb` are latched on entry to RUN and on every frame wrap. Changes mid-frame take effect at the next frame.
- Pixel coordinates:
  - ax = h_cnt - (H_SYNC+H_BP).
  - Pixel x for port p = ax*NUM_PORTS + p.
  - y = v_cnt - (V_SYNC+V_BP).
- Patterns (all three components equal unless stated):
  - Mode 0: each port outputs the latched `solid_rgb`.
  - Mode 1: x[DATA_W-1:0]; truncation wraps, e.g. 256 maps to 0 at DATA_W=8.
  - Mode 2: y[DATA_W-1:0].
  - Mode 3: all ones if x[CHK_SHIFT]^y[CHK_SHIFT] is 1, else 0.
- `pix` is 0 whenever DE is inactive.
- `frame_cnt` increments by 1 with each `frame_start`, wrapping from 0xFFFF to 0.

## Timing
- All outputs are registered, with one clock of latency from the counter state. `vs`, `hs`, `de`, `pix` and `frame_start` are mutually cycle-aligned.
- `frame_start` is high on the first output clock of VSYNC, i.e. the clock whose counters were h=0, v=0.
- Start-up: `en`=1 with the FSM in IDLE at edge k gives RUN at k+1 and `vs`/`hs` active at k+2.
- Reset values, on the edge after `rst`=1, override everything:
  - State IDLE, counters 0.
  - `hs`=~HS_POL and `vs`=~VS_POL.
  - `de`=0, `pix`=0, `frame_start`=0, `frame_cnt`=0.
- Reset mid-frame applies the same values immediately, with no completion of the current frame.
- In IDLE, the latched mode holds its last value.

## Test plan
Small configuration for all scenarios: NUM_PORTS=2, DATA_W=8, H_SYNC=2, H_BP=2, H_ACTIVE=4, H_FP=2 (H_TOTAL=10), V_SYNC=1, V_BP=1, V_ACTIVE=3, V_FP=1 (V_TOTAL=6), HS_POL=VS_POL=0.
- Reset and start-up:
  - Stimulus: hold `rst` 3 clocks with `en`=1, then release.
  - Outputs are idle during reset (`hs`=`vs`=1, `de`=0). `vs`=0 and `frame_start`=1 two clocks after release.
  - Each line has `hs` low for 2 clocks of 10. `vs` is low for 10 clocks per 60-clock frame.
- DE window:
  - `de` is high for 4 consecutive clocks, starting 4 clocks after `hs` falls, on 3 lines per frame.
  - That gives 12 DE clocks and 24 pixels per frame.
- Mode 1 h-ramp:
  - Stimulus: `mode`=1 for the whole frame.
  - Per active line, the pixels in order (port 0, port 1 per clock) are {0,1},{2,3},{4,5},{6,7}, with R=G=B.
  - `pix`=0 outside DE.
- Mode change mid-frame:
  - Stimulus: switch `mode` 0→2 at v_cnt=3.
  - The rest of that frame stays at `solid_rgb`=0x123456. The next frame's lines carry R=G=B=0, 1, 2.
- `en` dropped mid-frame:
  - Stimulus: deassert `en` at v_cnt=2.
  - The frame completes all 60 clocks, then outputs go idle with no further `frame_start`.
  - `frame_cnt` increments only per completed start. Re-asserting `en` restarts at h=v=0.
- Reset mid-frame and counter wrap:
  - Assert `rst` during DE: the next edge gives `de`=0, `pix`=0, `frame_cnt`=0.
  - Force `frame_cnt` to 0xFFFF; the next `frame_start` gives 0x0000.
